branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_pkg.sv | 47 ++++
 rtl/bru_meta_fifo.sv | 62 ++++++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Purpose: shared types for the branch resolve unit (funct3 encodings, widths, FSM states, metadata record).
// Latency: none, declarations and one combinational helper only.
// Backpressure: not applicable.
package branch_resolve_unit_pkg;

    localparam int XLEN      = 32;
    localparam int PHT_IDX_W = 3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // One in-flight predicted branch as recorded at ID.
    typedef struct packed {
        logic                 taken;
        logic [PHT_IDX_W-1:0] pht_index;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      target;
    } meta_t;

    // Branch condition evaluation; the unused encodings 010/011 resolve not-taken.
    function automatic logic branch_taken(input logic [2:0]      funct3,
                                          input logic [XLEN-1:0] rs1,
                                          input logic [XLEN-1:0] rs2);
        logic t;
        t = 1'b0;
        case (funct3)
            F3_BEQ:  t = (rs1 == rs2);
            F3_BNE:  t = (rs1 != rs2);
            F3_BLT:  t = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  t = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: t = (rs1 <  rs2);
            F3_BGEU: t = (rs1 >= rs2);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/bru_meta_fifo.sv
// Purpose: small synchronous FIFO holding predicted-branch metadata, with a one-cycle clear.
// Latency: head visible combinationally; a push is visible at the head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; clear overrides push/pop.
module bru_meta_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // At full the slot being read this cycle is the one being overwritten, so push+pop is safe.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose: resolves EX-stage conditional branches against queued ID predictions; redirects and flushes on mispredict.
// Latency: resolution/redirect registered 1 cycle after pop; flush held FLUSH_CYCLES cycles from that point.
// Backpressure: meta_full blocks new pushes (except with a same-cycle pop); pushes and ex_valid ignored while flushing.
// Optional: BRU_PERF_CNT_EN adds resolved_count / mispredict_count outputs.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    input  logic [PHT_IDX_W-1:0] pred_pht_index,
    input  logic [XLEN-1:0]      pred_pc,
    input  logic [XLEN-1:0]      pred_target,
    input  logic                 stall,
    input  logic                 ex_valid,
    input  logic [2:0]           ex_funct3,
    input  logic [XLEN-1:0]      ex_rs1,
    input  logic [XLEN-1:0]      ex_rs2,
    output logic                 branch_resolved,
    output logic                 actual_taken,
    output logic [PHT_IDX_W-1:0] pht_indexMEM,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 flush,
    output logic                 meta_full,
    output logic                 err_sticky
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]          resolved_count,
    output logic [31:0]          mispredict_count
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t          state;
    logic [2:0]      flush_cnt;
    meta_t           push_dat;
    meta_t           head_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic            idle;
    logic            push_req;
    logic            push_en;
    logic            push_drop;
    logic            pop_en;
    logic            pop_err;
    logic            ex_taken;
    logic            mispredict;
    logic [XLEN-1:0] fix_pc;

    assign idle       = (state == IDLE);
    assign push_req   = pred_valid && !stall && idle;
    assign pop_en     = ex_valid && !fifo_empty && idle;
    assign pop_err    = ex_valid && fifo_empty && idle;
    assign push_en    = push_req && (!fifo_full || pop_en);
    assign push_drop  = push_req && fifo_full && !pop_en;
    assign ex_taken   = branch_taken(ex_funct3, ex_rs1, ex_rs2);
    assign mispredict = pop_en && (ex_taken != head_dat.taken);
    assign fix_pc     = ex_taken ? head_dat.target : (head_dat.pc + 32'd4);
    assign meta_full  = fifo_full;

    assign push_dat = '{taken:     pred_taken,
                        pht_index: pred_pht_index,
                        pc:        pred_pc,
                        target:    pred_target};

    // A mispredict squashes every younger queued branch, including one pushed this same cycle.
    bru_meta_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(meta_t))
    ) u_meta_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_en),
        .pop     (pop_en),
        .clear   (mispredict),
        .wr_data (push_dat),
        .rd_data (head_dat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Resolution outputs plus IDLE/FLUSH control; flush rises together with redirect_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            flush_cnt       <= '0;
            flush           <= 1'b0;
            branch_resolved <= 1'b0;
            actual_taken    <= 1'b0;
            pht_indexMEM    <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            err_sticky      <= 1'b0;
        end else begin
            branch_resolved <= pop_en;
            redirect_valid  <= mispredict;
            if (push_drop || pop_err) err_sticky <= 1'b1;
            if (pop_en) begin
                actual_taken <= ex_taken;
                pht_indexMEM <= head_dat.pht_index;
                redirect_pc  <= fix_pc;
            end
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Event counters advance on the same edge that raises branch_resolved / redirect_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_count   <= '0;
            mispredict_count <= '0;
        end else begin
            if (pop_en)     resolved_count   <= resolved_count + 32'd1;
            if (mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int FLCY  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_taken = 1'b0;
    logic [2:0]  pred_pht_index = '0;
    logic [31:0] pred_pc = '0;
    logic [31:0] pred_target = '0;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic        branch_resolved;
    logic        actual_taken;
    logic [2:0]  pht_indexMEM;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        meta_full;
    logic        err_sticky;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] resolved_count;
    logic [31:0] mispredict_count;
`endif

    branch_resolve_unit #(.FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pht_index(pred_pht_index),
        .pred_pc(pred_pc), .pred_target(pred_target), .stall(stall),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .branch_resolved(branch_resolved), .actual_taken(actual_taken), .pht_indexMEM(pht_indexMEM),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .meta_full(meta_full), .err_sticky(err_sticky)
`ifdef BRU_PERF_CNT_EN
        , .resolved_count(resolved_count), .mispredict_count(mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        tk;
        bit [2:0]  idx;
        bit [31:0] pc;
        bit [31:0] tgt;
    } ent_t;

    // Reference model: queue of outstanding predictions plus remaining flush cycles.
    ent_t      mq[$];
    int        flush_left;
    bit        m_err;
    bit        e_res, e_tk, e_rv;
    bit [2:0]  e_idx;
    bit [31:0] e_rpc;
    bit [31:0] e_rc, e_mc;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit ref_taken(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) <  $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a <  b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        mq.delete();
        flush_left = 0;
        m_err = 0; e_res = 0; e_tk = 0; e_rv = 0; e_idx = 0; e_rpc = 0; e_rc = 0; e_mc = 0;
    endfunction

    // Drive one cycle of inputs, advance the model, then land 1ns past the edge.
    task automatic cycle(input bit pv, input bit pt, input bit [2:0] pidx, input bit [31:0] ppc,
                         input bit [31:0] ptgt, input bit stl, input bit exv, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] b);
        ent_t h;
        bit   do_pop, do_push, tk, mis;
        pred_valid = pv; pred_taken = pt; pred_pht_index = pidx; pred_pc = ppc; pred_target = ptgt;
        stall = stl; ex_valid = exv; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
        e_res = 0; e_rv = 0; mis = 0;
        if (flush_left == 0) begin
            do_pop  = exv && (mq.size() > 0);
            do_push = 0;
            if (exv && mq.size() == 0) m_err = 1;
            if (pv && !stl) begin
                if (mq.size() < DEPTH || do_pop) do_push = 1;
                else m_err = 1;
            end
            if (do_pop) begin
                h     = mq.pop_front();
                tk    = ref_taken(f3, a, b);
                e_res = 1; e_tk = tk; e_idx = h.idx;
                e_rpc = tk ? h.tgt : h.pc + 32'd4;
                mis   = (tk != h.tk);
                e_rv  = mis;
                e_rc  = e_rc + 1;
                if (mis) e_mc = e_mc + 1;
            end
            if (do_push) mq.push_back('{tk: pt, idx: pidx, pc: ppc, tgt: ptgt});
            if (mis) begin
                mq.delete();
                flush_left = FLCY;
            end
        end else begin
            flush_left = flush_left - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pred_valid = 0; ex_valid = 0; stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (branch_resolved !== 1'b0) begin n_fail++; $display("FAIL reset_resolved got=%b exp=0", branch_resolved); end
        n_tests++; if (actual_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got=%b exp=0", actual_taken); end
        n_tests++; if (pht_indexMEM !== 3'b000) begin n_fail++; $display("FAIL reset_idx got=%h exp=0", pht_indexMEM); end
        n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
        n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush); end
        n_tests++; if (meta_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", meta_full); end
        n_tests++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_correct_taken();
        cycle(1, 1, 3'd5, 32'h100, 32'h140, 0, 0, 3'd0, 32'd0, 32'd0);
        n_tests++; if (branch_resolved !== 1'b0) begin n_fail++; $display("FAIL beq_push_no_res got=%b exp=0", branch_resolved); end
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b000, 32'd5, 32'd5);
        n_tests++; if (branch_resolved !== 1'b1) begin n_fail++; $display("FAIL beq_res got=%b exp=1", branch_resolved); end
        n_tests++; if (actual_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken got=%b exp=1", actual_taken); end
        n_tests++; if (pht_indexMEM !== 3'd5) begin n_fail++; $display("FAIL beq_idx got=%0d exp=5", pht_indexMEM); end
        n_tests++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL beq_no_redirect rv=%b flush=%b exp=0/0", redirect_valid, flush); end
        idle(1);
        n_tests++; if (branch_resolved !== 1'b0) begin n_fail++; $display("FAIL beq_res_pulse got=%b exp=0", branch_resolved); end
    endtask

    task automatic test_mispredict_bne();
        cycle(1, 0, 3'd6, 32'h200, 32'h180, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b001, 32'd1, 32'd2);
        n_tests++; if (redirect_valid !== 1'b1 || branch_resolved !== 1'b1) begin n_fail++; $display("FAIL bne_rv rv=%b res=%b exp=1/1", redirect_valid, branch_resolved); end
        n_tests++; if (redirect_pc !== 32'h180) begin n_fail++; $display("FAIL bne_rpc got=%h exp=00000180", redirect_pc); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL bne_flush1 got=%b exp=1", flush); end
        idle(1);
        n_tests++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_flush2 flush=%b rv=%b exp=1/0", flush, redirect_valid); end
        idle(1);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bne_flush_end got=%b exp=0", flush); end
    endtask

    task automatic test_wrap();
        cycle(1, 1, 3'd2, 32'hFFFF_FFFC, 32'h40, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b100, 32'd5, 32'hFFFF_FFFD);
        n_tests++; if (actual_taken !== 1'b0) begin n_fail++; $display("FAIL blt_taken got=%b exp=0", actual_taken); end
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL blt_wrap rv=%b rpc=%h exp=1/00000000", redirect_valid, redirect_pc); end
        idle(2);
    endtask

    task automatic test_flush_squash();
        cycle(1, 1, 3'd1, 32'h300, 32'h380, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(1, 1, 3'd2, 32'h310, 32'h390, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(1, 1, 3'd3, 32'h320, 32'h3A0, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b000, 32'd1, 32'd2);
        n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin n_fail++; $display("FAIL squash_rv rv=%b rpc=%h exp=1/00000304", redirect_valid, redirect_pc); end
        cycle(1, 0, 3'd4, 32'h400, 32'h440, 0, 1, 3'b000, 32'd7, 32'd7);
        n_tests++; if (branch_resolved !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL squash_ign1 res=%b flush=%b exp=0/1", branch_resolved, flush); end
        cycle(1, 0, 3'd4, 32'h400, 32'h440, 0, 1, 3'b000, 32'd7, 32'd7);
        n_tests++; if (branch_resolved !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL squash_ign2 res=%b flush=%b exp=0/0", branch_resolved, flush); end
        n_tests++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL squash_err_clean got=%b exp=0", err_sticky); end
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b000, 32'd7, 32'd7);
        n_tests++; if (branch_resolved !== 1'b0 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL squash_empty res=%b err=%b exp=0/1", branch_resolved, err_sticky); end
    endtask

    task automatic test_overflow();
        bit [31:0] exp_tgt [4];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 3'(i), 32'h1000 + 32'(i * 8), 32'h2000 + 32'(i * 16), 0, 0, 3'd0, 32'd0, 32'd0);
            if (i == 2) begin
                n_tests++; if (meta_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full3 got=%b exp=0", meta_full); end
            end
            if (i == 3) begin
                n_tests++; if (meta_full !== 1'b1 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_full4 full=%b err=%b exp=1/0", meta_full, err_sticky); end
            end
        end
        n_tests++; if (meta_full !== 1'b1 || err_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_drop full=%b err=%b exp=1/1", meta_full, err_sticky); end
        cycle(1, 1, 3'd5, 32'h1100, 32'h3000, 0, 1, 3'b000, 32'd7, 32'd7);
        n_tests++; if (branch_resolved !== 1'b1 || redirect_pc !== 32'h2000 || meta_full !== 1'b1) begin n_fail++; $display("FAIL ovf_pushpop res=%b rpc=%h full=%b exp=1/00002000/1", branch_resolved, redirect_pc, meta_full); end
        exp_tgt = '{32'h2010, 32'h2020, 32'h2030, 32'h3000};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b000, 32'd9, 32'd9);
            n_tests++; if (branch_resolved !== 1'b1 || redirect_pc !== exp_tgt[i] || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain%0d res=%b rpc=%h rv=%b exp=1/%h/0", i, branch_resolved, redirect_pc, redirect_valid, exp_tgt[i]); end
        end
        n_tests++; if (meta_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", meta_full); end
    endtask

    task automatic test_random();
        logic [40:0] got, exp;
        bit [31:0]   a, b;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = a; end
                1: begin a = $urandom; b = $urandom; end
                2: begin a = 32'($urandom_range(0, 8)) - 32'd4; b = 32'($urandom_range(0, 8)) - 32'd4; end
                default: begin a = $urandom; b = a ^ 32'h8000_0000; end
            endcase
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 4, 3'($urandom), a, b);
            got = {branch_resolved, actual_taken, pht_indexMEM, redirect_valid, redirect_pc, flush, meta_full, err_sticky};
            exp = {e_res, e_tk, e_idx, e_rv, e_rpc, flush_left > 0, mq.size() == DEPTH, m_err};
            n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rand_cycle%0d got=%h exp=%h", n, got, exp); end
`ifdef BRU_PERF_CNT_EN
            n_tests++; if (resolved_count !== e_rc || mispredict_count !== e_mc) begin n_fail++; $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d", n, resolved_count, mispredict_count, e_rc, e_mc); end
`endif
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        cycle(1, 1, 3'd3, 32'h500, 32'h580, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b001, 32'd4, 32'd4);
        idle(1);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got=%b exp=1", flush); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (flush !== 1'b0 || redirect_pc !== 32'h0 || pht_indexMEM !== 3'd0 || actual_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_async flush=%b rpc=%h idx=%0d tk=%b exp=0/0/0/0", flush, redirect_pc, pht_indexMEM, actual_taken); end
`ifdef BRU_PERF_CNT_EN
        n_tests++; if (resolved_count !== 32'd0 || mispredict_count !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", resolved_count, mispredict_count); end
`endif
        #2;
        rst_n = 1'b1;
        model_reset();
        cycle(1, 0, 3'd6, 32'h600, 32'h640, 0, 0, 3'd0, 32'd0, 32'd0);
        cycle(0, 0, 3'd0, 32'd0, 32'd0, 0, 1, 3'b001, 32'd8, 32'd8);
        n_tests++; if (branch_resolved !== 1'b1 || pht_indexMEM !== 3'd6 || redirect_valid !== 1'b0 || err_sticky !== 1'b0) begin n_fail++; $display("FAIL midrst_push res=%b idx=%0d rv=%b err=%b exp=1/6/0/0", branch_resolved, pht_indexMEM, redirect_valid, err_sticky); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_correct_taken();
        test_mispredict_bne();
        test_wrap();
        test_flush_squash();
        test_overflow();
        test_random();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
